// File: rtl/uart_pkg.sv
// Constants shared by the UART receive and transmit paths.
package uart_pkg;

   localparam int UART_WORD_SIZE     = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;

   // The extra MSB is a wrap bit, so the pointers can tell full from empty.
   function automatic int fifo_ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port word array: synchronous write, asynchronous indexed read.
// No reset on the contents. Also used as storage for the TX FIFO.
module uart_fifo_mem #(
   parameter int WORD_SIZE = 8,
   parameter int DEPTH     = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WORD_SIZE-1:0]     wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WORD_SIZE-1:0]     rdata
);

   logic [WORD_SIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive word buffer with a first-word-fall-through read port and a sticky overrun flag.
// Define UART_RX_FIFO_WATERMARK_EN to build the registered wm_irq fill-level output.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WORD_SIZE = UART_WORD_SIZE,
   parameter int DEPTH     = UART_RX_FIFO_DEPTH,
   parameter int WATERMARK = DEPTH / 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WORD_SIZE-1:0]       rx_data,
   input  logic                       rx_avbl,
   output logic [WORD_SIZE-1:0]       rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       empty,
   output logic                       full,
   output logic                       overrun,
   input  logic                       overrun_clr,
   output logic                       wm_irq
);

   localparam int PW = fifo_ptr_width(DEPTH);
   localparam int IW = PW - 1;

   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 push, pop, drop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
   assign level    = wr_ptr - rd_ptr;
   assign rd_valid = ~empty;
   assign rd_data  = empty ? '0 : mem_rdata;

   // A pop on the same edge frees the slot, so a full FIFO still accepts the word.
   assign pop  = rd_valid & rd_ready;
   assign push = rx_avbl & (~full | pop);
   assign drop = rx_avbl & full & ~pop;

   uart_fifo_mem #(
      .WORD_SIZE (WORD_SIZE),
      .DEPTH     (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~rst),
      .waddr (wr_ptr[IW-1:0]),
      .wdata (rx_data),
      .raddr (rd_ptr[IW-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         // Set wins over clear so a drop is never lost.
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_WATERMARK_EN
   logic [PW-1:0] level_nxt;

   assign level_nxt = (wr_ptr + PW'(push)) - (rd_ptr + PW'(pop));

   always_ff @(posedge clk) begin
      if (rst) wm_irq <= 1'b0;
      else     wm_irq <= (level_nxt >= PW'(WATERMARK));
   end
`else
   assign wm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps plus random traffic against a queue model.
module tb_uart_rx_fifo;

   localparam int WS    = 8;
   localparam int DEPTH = 16;
   localparam int WM    = DEPTH / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [WS-1:0] rx_data = '0;
   logic          rx_avbl = 1'b0;
   logic [WS-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [4:0]    level;
   logic          empty, full, overrun;
   logic          overrun_clr = 1'b0;
   logic          wm_irq;

   int checks = 0;
   int errors = 0;

   // Reference model: the stored words in arrival order plus the sticky flag.
   logic [WS-1:0] q[$];
   logic          m_ovr = 1'b0;
   logic          m_wm  = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.WORD_SIZE(WS), .DEPTH(DEPTH), .WATERMARK(WM)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_avbl     (rx_avbl),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .level       (level),
      .empty       (empty),
      .full        (full),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .wm_irq      (wm_irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
      chk({tag, ":rd_data"},  32'(rd_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk({tag, ":level"},    32'(level),    32'(q.size()));
      chk({tag, ":empty"},    32'(empty),    32'(q.size() == 0));
      chk({tag, ":full"},     32'(full),     32'(q.size() == DEPTH));
      chk({tag, ":overrun"},  32'(overrun),  32'(m_ovr));
      chk({tag, ":wm_irq"},   32'(wm_irq),   32'(m_wm));
   endtask

   // One clock: drive inputs, advance the model at the edge, then compare.
   task automatic step(input string tag, input logic r, input logic av, input logic [WS-1:0] d,
                       input logic rdy, input logic clr);
      logic was_full, do_pop;
      rst = r; rx_avbl = av; rx_data = d; rd_ready = rdy; overrun_clr = clr;
      was_full = (q.size() == DEPTH);
      do_pop   = rdy && (q.size() != 0);
      @(posedge clk);
      if (r) begin
         q.delete();
         m_ovr = 1'b0;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (av && (!was_full || do_pop)) q.push_back(d);
         if (av && was_full && !do_pop) m_ovr = 1'b1;
         else if (clr)                  m_ovr = 1'b0;
      end
`ifdef UART_RX_FIFO_WATERMARK_EN
      m_wm = !r && (q.size() >= WM);
`else
      m_wm = 1'b0;
`endif
      #1;
      rx_avbl = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0; rst = 1'b0;
      check_all(tag);
   endtask

   initial begin
      // Reset, with a receiver pulse in the reset cycle that must be ignored.
      step("reset", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      step("idle", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Single word round trip.
      step("push_a5", 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      chk("a5_data", 32'(rd_data), 32'hA5);
      chk("a5_level", 32'(level), 32'd1);
      step("pop_a5", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("a5_empty", 32'(empty), 32'd1);

      // Fill to the brim, then one dropped word.
      for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(level), 32'd16);
      step("drop_ff", 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      chk("drop_ovr", 32'(overrun), 32'd1);

      // Clear together with another drop: set wins; clear alone then works.
      step("clr_drop", 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clr_drop_ovr", 32'(overrun), 32'd1);
      step("clr_only", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_only_ovr", 32'(overrun), 32'd0);

      // Push while full with a simultaneous pop: accepted, no overrun.
      step("full_pushpop", 1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("pushpop_level", 32'(level), 32'd16);
      chk("pushpop_ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("last_is_77", 32'(rd_data), 32'h77);
         step("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // 20 interleaved push/pop pairs, crossing the pointer wrap more than once.
      for (int i = 0; i < 20; i++) begin
         step("il_push", 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
         step("il_push2", 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0);
         step("il_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      while (q.size() != 0) step("il_drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Watermark threshold walk (wm_irq stays 0 when the feature is compiled out).
      for (int i = 0; i < WM; i++) step("wm_push", 1'b0, 1'b1, 8'(i + 8'h40), 1'b0, 1'b0);
      step("wm_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with occasional clears and a mid-stream reset.
      for (int i = 0; i < 400; i++) begin
         step("rand", (i == 250), ($urandom_range(0, 99) < 55), 8'($urandom),
              ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10));
      end

      // Reset while data is held flushes at once.
      step("pre_rst", 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
      step("mid_rst", 1'b1, 1'b1, 8'h5B, 1'b1, 1'b0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side word buffer sitting directly downstream of the UART receiver. It captures each word the receiver flags as available with a one-cycle pulse and stores it in a circular buffer. Words are presented to the controller through a first-word-fall-through valid/ready read port. Overflow is flagged through a sticky overrun bit, so the controller can service bytes in bursts rather than within one character time.

## Interface
- WORD_SIZE, 8, bits per received word; must match the receiver's word size.
- DEPTH, 16, number of stored words; power of two, ≥ 2.
- WATERMARK, DEPTH/2, fill level (1..DEPTH) at which wm_irq asserts; used only with UART_RX_FIFO_WATERMARK_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  WORD_SIZE  word from receiver; sampled only when rx_avbl = 1.
- rx_avbl  in  1  one-cycle "word available" pulse from receiver.
- rd_data  out  WORD_SIZE  oldest stored word; 0 when empty.
- rd_valid  out  1  high when at least one word is stored (= ~empty).
- rd_ready  in  1  controller accepts rd_data; a pop occurs when rd_valid & rd_ready.
- level  out  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- overrun  out  1  sticky; a word arrived while full and was dropped.
- overrun_clr  in  1  clears overrun.
- wm_irq  out  1  level ≥ WATERMARK; tied 0 when the feature is compiled out.

## Operation
- Storage: DEPTH × WORD_SIZE array with no reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits.
  - The MSB is the wrap bit; the low bits index the array.
  - Both wrap naturally modulo 2·DEPTH.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - level = wr_ptr − rd_ptr (modulo arithmetic, same width).
- Push: on rx_avbl & (~full | pop).
  - Write rx_data at wr_ptr[idx], then increment wr_ptr.
- Drop: on rx_avbl & full & ~pop.
  - Word is discarded; pointers unchanged; overrun ← 1.
- Pop: on rd_valid & rd_ready; increment rd_ptr.
  - rd_ready while empty has no effect.
- Simultaneous push and pop:
  - Both occur; level unchanged.
  - When full, the arriving word is accepted (the pop frees a slot at the same edge); no overrun.
- Overrun:
  - Set by a drop, cleared by overrun_clr.
  - Drop and clear in the same cycle → overrun = 1 (set wins).
- No internal state machine beyond pointer and flag registers. The write enable is combinational from rx_avbl, so no receiver pulse is ever missed.

## Timing
- Reset (rst = 1 at an edge): both pointers 0, overrun 0, wm_irq 0. Therefore level 0, empty 1, full 0, rd_valid 0, rd_data 0.
  - Stored contents are abandoned.
  - An rx_avbl in the reset cycle is ignored.
- Reset mid-operation: flushes immediately; no partial pop or push completes in that cycle.
- Write-to-read latency: a word pushed at edge N is visible on rd_data/rd_valid in the cycle after edge N.
  - No empty-bypass: rd_valid never asserts in the same cycle as rx_avbl.
- rd_data, rd_valid, level, empty and full are combinational from the registered pointers and array.
  - They update one edge after any push, pop or reset.
- Back-to-back pops: sustained one pop per cycle while level > 0.
- The receiver delivers at most one word per character time. The block still supports a push on every cycle.
- wm_irq is registered: it reflects the level resulting from the edge on which it updates, so it has the same timing as level.

## Configuration
- UART_RX_FIFO_WATERMARK_EN defined:
  - wm_irq register is present.
  - wm_irq = 1 while the post-update level ≥ WATERMARK, 0 otherwise.
  - Level-sensitive; not sticky.
- UART_RX_FIFO_WATERMARK_EN undefined:
  - No comparator or register is built.
  - wm_irq is driven constant 0.
  - WATERMARK is ignored.
- All other behaviour is identical in both builds.

## Structure
- Shared package uart_pkg:
  - default WORD_SIZE, default RX FIFO depth constant;
  - a function returning the pointer width for a given depth.
- The receiver and transmitter share these constants.
- One sub-module, uart_fifo_mem: a simple dual-port array with a synchronous write port and asynchronous read by index.
  - The same sub-module is reused later for the TX FIFO.
- All pointer, flag and watermark logic stays in uart_rx_fifo.

## Test plan
- Reset, then push 0xA5 with a single rx_avbl pulse → next cycle rd_valid = 1, rd_data = 0xA5, level = 1; pop → empty = 1, rd_data = 0.
- Push 16 words 0x00..0x0F with DEPTH = 16 → full = 1, level = 16; a 17th push of 0xFF → overrun = 1, then pops return exactly 0x00..0x0F in order.
- Full FIFO, push 0x77 with rd_ready = 1 in the same cycle → no overrun, level stays 16, and the last of the next 16 pops returns 0x77.
- Overrun set, then overrun_clr asserted together with another dropped push → overrun stays 1; overrun_clr alone on the next cycle → overrun = 0.
- Push 20 and pop 20 words interleaved, crossing the pointer wrap twice → data order preserved and level always matches the reference model; rst asserted mid-stream → level = 0, rd_valid = 0 the next cycle.
- With UART_RX_FIFO_WATERMARK_EN and WATERMARK = 8:
  - 7 pushes → wm_irq = 0; the 8th → wm_irq = 1; one pop → wm_irq = 0.
  - Without the macro, wm_irq stays 0 throughout.
